// File: rtl/parking_lot_controller_if.sv
// Sensor inputs and occupancy/strobe outputs of the parking-lot gate controller.
interface parking_lot_controller_if #(
  parameter int unsigned CNT_W = 5
);
  logic             outer;
  logic             inner;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             enter;
  logic             exit;
  logic             reject;
  logic             busy;

  modport master (
    output outer, inner,
    input  count, full, empty, enter, exit, reject, busy
  );

  modport slave (
    input  outer, inner,
    output count, full, empty, enter, exit, reject, busy
  );
endinterface

// File: rtl/parking_lot_controller.sv
// Single-lane gate sequencer: synchronises the photo sensors, follows each car
// through the four-phase beam pattern and keeps a saturating occupancy count.
module parking_lot_controller #(
  parameter int unsigned CAPACITY = 25,
  parameter int unsigned CNT_W    = 5
) (
  input logic                     clk,
  input logic                     reset,
  parking_lot_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, REJ
  } state_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       w_oi;
  logic [CNT_W-1:0] r_count;
  logic             r_enter;
  logic             r_exit;
  logic             r_reject;
  logic             w_enter_nxt;
  logic             w_exit_nxt;
  logic             w_reject_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;

  // Two-flop synchroniser per sensor; pair is kept as {outer, inner}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {bus.outer, bus.inner};
      r_sync2 <= r_sync1;
    end
  end

  assign w_oi    = r_sync2;
  assign w_full  = (r_count == CAP);
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_enter  <= 1'b0;
      r_exit   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_enter  <= w_enter_nxt;
      r_exit   <= w_exit_nxt;
      r_reject <= w_reject_nxt;
      if (w_enter_nxt)
        r_count <= r_count + CNT_W'(1);
      else if (w_exit_nxt)
        r_count <= r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_nxt  = 1'b0;
    w_exit_nxt   = 1'b0;
    w_reject_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_oi == 2'b10) begin
          if (w_full) begin
            w_state_nxt  = REJ;
            w_reject_nxt = 1'b1;
          end else begin
            w_state_nxt = EN1;
          end
        end else if (w_oi == 2'b01) begin
          if (w_empty) begin
            w_state_nxt  = REJ;
            w_reject_nxt = 1'b1;
          end else begin
            w_state_nxt = EX1;
          end
        end
      end
      EN1: begin
        case (w_oi)
          2'b10:   w_state_nxt = EN1;
          2'b11:   w_state_nxt = EN2;
          default: w_state_nxt = IDLE;
        endcase
      end
      EN2: begin
        case (w_oi)
          2'b11:   w_state_nxt = EN2;
          2'b01:   w_state_nxt = EN3;
          2'b10:   w_state_nxt = EN1;
          default: w_state_nxt = IDLE;
        endcase
      end
      EN3: begin
        case (w_oi)
          2'b01: w_state_nxt = EN3;
          2'b11: w_state_nxt = EN2;
          2'b10: w_state_nxt = IDLE;
          default: begin
            w_state_nxt = IDLE;
            w_enter_nxt = !w_full;
          end
        endcase
      end
      EX1: begin
        case (w_oi)
          2'b01:   w_state_nxt = EX1;
          2'b11:   w_state_nxt = EX2;
          default: w_state_nxt = IDLE;
        endcase
      end
      EX2: begin
        case (w_oi)
          2'b11:   w_state_nxt = EX2;
          2'b10:   w_state_nxt = EX3;
          2'b01:   w_state_nxt = EX1;
          default: w_state_nxt = IDLE;
        endcase
      end
      EX3: begin
        case (w_oi)
          2'b10: w_state_nxt = EX3;
          2'b11: w_state_nxt = EX2;
          2'b01: w_state_nxt = IDLE;
          default: begin
            w_state_nxt = IDLE;
            w_exit_nxt  = !w_empty;
          end
        endcase
      end
      REJ: begin
        if (w_oi == 2'b00)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  assign bus.count  = r_count;
  assign bus.full   = w_full;
  assign bus.empty  = w_empty;
  assign bus.enter  = r_enter;
  assign bus.exit   = r_exit;
  assign bus.reject = r_reject;
  assign bus.busy   = w_busy;

endmodule
